mult_datapath: RTL

- Shift-add multiplier datapath sitting directly downstream of the multiplier control FSM.
- Consumes the FSM's Load/Ad/Sh/Done strobes and returns M (current multiplier LSB) and K (last shift).
- Holds the multiplicand, the combined accumulator/multiplier register and the shift counter.
- Captures the finished product into a result register with a one-cycle valid pulse for the consuming stage.

---
 rtl/mult_pkg.sv | 26 ++
 rtl/mult_shift_counter.sv | 42 ++++
 rtl/mult_datapath.sv | 116 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and defaults for the shift-add multiplier slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int N_DEFAULT = 4;

    // Strobes arriving from the multiplier control FSM.
    typedef struct packed {
        logic load;
        logic ad;
        logic sh;
        logic done;
    } ctrl_t;

    // Status returned to the control FSM.
    typedef struct packed {
        logic m;
        logic k;
    } status_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_shift_counter.sv
`default_nettype none
// ============================================================================
// Module      : mult_shift_counter
// Description : Counts completed shifts and flags the last (Nth) one.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_shift_counter #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Clr,
    input  logic          Inc,
    input  logic          Sh,
    output logic [CW-1:0] Count,
    output logic          K
);

    localparam logic [CW-1:0] c_last = CW'(N - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == c_last);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_count <= '0;
        end else if (Clr) begin
            r_count <= '0;
        end else if (Inc) begin
            // Explicit wrap so non-power-of-two N still cycles through 0..N-1.
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

    assign Count = r_count;
    assign K     = Sh & w_at_last;

endmodule : mult_shift_counter
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mult_datapath
// Description : Shift-add multiplier datapath driven by the control FSM
//               strobes; holds operands, accumulator and the result register.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_datapath
    import mult_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = $clog2(N)
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic [N-1:0]   Multiplicand,
    input  logic [N-1:0]   Multiplier,
    input  logic           Load,
    input  logic           Ad,
    input  logic           Sh,
    input  logic           Done,
    output logic           M,
    output logic           K,
    output logic           Busy,
    output logic [2*N-1:0] Product,
    output logic           Valid
);

    ctrl_t          w_ctrl;
    status_t        w_status;
    logic           w_lde;
    logic           w_cnt_inc;
    logic           w_k_raw;
    logic [N:0]     w_sum;
    logic [CW-1:0]  w_count;

    logic [2*N:0]   r_acc;
    logic [N-1:0]   r_mcand;
    logic           r_load_q;
    logic           r_busy;
    logic [2*N-1:0] r_product;
    logic           r_valid;

    assign w_ctrl    = '{load: Load, ad: Ad, sh: Sh, done: Done};
    assign w_lde     = w_ctrl.load & ~r_load_q;
    assign w_cnt_inc = w_ctrl.sh & ~w_lde;
    assign w_sum     = {1'b0, r_acc[2*N-1:N]} + {1'b0, r_mcand};

    mult_shift_counter #(
        .N  (N),
        .CW (CW)
    ) u_shift_counter (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clr   (w_lde),
        .Inc   (w_cnt_inc),
        .Sh    (w_ctrl.sh),
        .Count (w_count),
        .K     (w_k_raw)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_load_q <= 1'b0;
        end else begin
            r_load_q <= w_ctrl.load;
            if (w_lde) begin
                r_acc   <= {{(N+1){1'b0}}, Multiplier};
                r_mcand <= Multiplicand;
            end else if (w_ctrl.ad && w_ctrl.sh) begin
                r_acc <= {1'b0, w_sum, r_acc[N-1:1]};
            end else if (w_ctrl.ad) begin
                r_acc[2*N:N] <= w_sum;
            end else if (w_ctrl.sh) begin
                r_acc <= {1'b0, r_acc[2*N:1]};
            end
        end
    end

    // Done samples the pre-load accumulator even when a new load lands on the same edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_busy    <= 1'b0;
            r_product <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_ctrl.done;
            if (w_ctrl.done) begin
                r_product <= r_acc[2*N-1:0];
            end
            if (w_lde) begin
                r_busy <= 1'b1;
            end else if (w_ctrl.done) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Status is forced low while reset is held, even if Load is asserted.
    assign w_status.m = ~Rst & (w_lde ? Multiplier[0] : r_acc[0]);
    assign w_status.k = ~Rst & w_k_raw;

    assign M       = w_status.m;
    assign K       = w_status.k;
    assign Busy    = r_busy;
    assign Product = r_product;
    assign Valid   = r_valid;

    // The counter value itself is only consumed through K.
    logic w_unused;
    assign w_unused = ^w_count;

endmodule : mult_datapath
`default_nettype wire
